// File: rtl/csr_vol_ramp_pkg.sv
// Shared constants for the volume CSR block: register offsets, ID value,
// CTRL bit positions, volume width helper and address-region decode.
package csr_vol_pkg;

  localparam logic [6:0] ADR_STEP    = 7'h40;
  localparam logic [6:0] ADR_PRE_LO  = 7'h41;
  localparam logic [6:0] ADR_PRE_HI  = 7'h42;
  localparam logic [6:0] ADR_CTRL    = 7'h43;
  localparam logic [6:0] ADR_STATUS  = 7'h44;
  localparam logic [6:0] ADR_ID      = 7'h45;

  // Shadow targets occupy base+0x00..0x1F, current volumes base+0x20..0x3F.
  localparam logic [6:0] SPAN_SHADOW = 7'h20;
  localparam logic [6:0] SPAN_VOLS   = 7'h40;

  localparam logic [7:0] ID_VALUE    = 8'hA2;

  localparam logic [2:0] CTRL_COMMIT = 3'd0;
  localparam logic [2:0] CTRL_MUTE   = 3'd1;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_SHADOW,
    REG_CUR,
    REG_STEP,
    REG_PRE_LO,
    REG_PRE_HI,
    REG_CTRL,
    REG_STATUS,
    REG_ID
  } reg_e;

  function automatic int unsigned vol_w(input int unsigned vol_bytes);
    return 8 * vol_bytes;
  endfunction

  // Fixed control registers take priority over the relocatable volume windows.
  function automatic reg_e decode(input logic [6:0] adr, input logic [6:0] base);
    logic [6:0] rel;
    rel = adr - base;
    case (adr)
      ADR_STEP:   return REG_STEP;
      ADR_PRE_LO: return REG_PRE_LO;
      ADR_PRE_HI: return REG_PRE_HI;
      ADR_CTRL:   return REG_CTRL;
      ADR_STATUS: return REG_STATUS;
      ADR_ID:     return REG_ID;
      default:    ;
    endcase
    if (rel < SPAN_SHADOW) return REG_SHADOW;
    if (rel < SPAN_VOLS)   return REG_CUR;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/csr_vol_ramp_if.sv
// Classic Wishbone slave bus for the volume CSR block.
interface csr_vol_ramp_if;
  logic [6:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_cyc_i;
  logic       wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/csr_vol_ramp_vol_ramp.sv
// Per-channel volume ramp: walks the current value toward the effective
// target by at most STEP per tick, without overshoot or wrap.
// CSR_VOL_RAMP_EN undefined: the value follows the target one cycle later.
module vol_ramp #(
  parameter int unsigned VOL_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CSR_VOL_RAMP_EN
  input  logic             tick,
  input  logic [7:0]       step,
`endif
  input  logic [VOL_W-1:0] target,
  output logic [VOL_W-1:0] cur,
  output logic             busy
);

`ifdef CSR_VOL_RAMP_EN
  logic [VOL_W-1:0] step_w;
  logic [VOL_W-1:0] dist;
  logic [VOL_W-1:0] delta;
  logic             rising;

  // Saturating step: never move further than the remaining distance.
  always_comb begin
    step_w = VOL_W'(step);
    rising = (target >= cur);
    dist   = rising ? (target - cur) : (cur - target);
    delta  = (step_w < dist) ? step_w : dist;
  end

  // Current value and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur  <= '0;
      busy <= 1'b0;
    end else begin
      busy <= (cur != target);
      if (step == 8'h00) begin
        cur <= target;
      end else if (tick) begin
        cur <= rising ? (cur + delta) : (cur - delta);
      end
    end
  end
`else
  // Without the ramp engine the output tracks the target directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= '0;
    end else begin
      cur <= target;
    end
  end

  assign busy = 1'b0;
`endif

endmodule

// File: rtl/csr_vol_ramp.sv
// Volume CSR block: Wishbone register decode, shadow/live target bytes with
// atomic COMMIT, MUTE, and the ramp prescaler feeding one vol_ramp per channel.
// Optional feature macro: CSR_VOL_RAMP_EN (ramp engine and prescaler).
module csr_vol_ramp
  import csr_vol_pkg::*;
#(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned VOL_BYTES        = 2,
  parameter logic [6:0]  ADDR_OFFSET_VOLS = 7'h00
) (
  input  logic                               clk,
  input  logic                               rst,
  csr_vol_ramp_if.slave                      wb,
  output logic [NUM_CH*vol_w(VOL_BYTES)-1:0] vol,
  output logic [NUM_CH-1:0]                  busy
);

  localparam int unsigned VOL_W = vol_w(VOL_BYTES);
  localparam int unsigned NB    = NUM_CH * VOL_BYTES;

  logic                    req;
  reg_e                    region;
  logic [4:0]              idx;
  logic [7:0]              rdata;
  logic [7:0]              shadow [NB];
  logic [7:0]              live   [NB];
  logic [7:0]              step;
  logic [15:0]             prescale;
  logic                    mute;
  logic [NUM_CH*VOL_W-1:0] eff;

  // The ack term blocks back-to-back acks on a held strobe.
  assign req    = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign region = decode(wb.wb_adr_i, ADDR_OFFSET_VOLS);
  assign idx    = 5'(wb.wb_adr_i - ADDR_OFFSET_VOLS);

  // Read mux; bytes beyond the configured channels read as zero.
  always_comb begin
    rdata = '0;
    case (region)
      REG_SHADOW: for (int unsigned k = 0; k < NB; k++) if (idx == 5'(k)) rdata = shadow[k];
      REG_CUR:    for (int unsigned k = 0; k < NB; k++) if (idx == 5'(k)) rdata = vol[k*8 +: 8];
      REG_STEP:   rdata = step;
      REG_PRE_LO: rdata = prescale[7:0];
      REG_PRE_HI: rdata = prescale[15:8];
      REG_CTRL:   rdata[CTRL_MUTE] = mute;
      REG_STATUS: rdata = 8'(busy);
      REG_ID:     rdata = ID_VALUE;
      default:    rdata = '0;
    endcase
  end

  // Effective target: live bytes, or zero while muted.
  always_comb begin
    eff = '0;
    for (int unsigned k = 0; k < NB; k++) eff[k*8 +: 8] = mute ? 8'h00 : live[k];
  end

  // Bus response and register writes, both on the edge that raises ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      step        <= 8'h01;
      prescale    <= '0;
      mute        <= 1'b0;
      for (int unsigned k = 0; k < NB; k++) begin
        shadow[k] <= '0;
        live[k]   <= '0;
      end
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= req ? rdata : '0;
      if (req && wb.wb_we_i) begin
        case (region)
          REG_SHADOW: for (int unsigned k = 0; k < NB; k++) if (idx == 5'(k)) shadow[k] <= wb.wb_dat_i;
          REG_STEP:   step <= wb.wb_dat_i;
          REG_PRE_LO: prescale[7:0] <= wb.wb_dat_i;
          REG_PRE_HI: prescale[15:8] <= wb.wb_dat_i;
          REG_CTRL: begin
            mute <= wb.wb_dat_i[CTRL_MUTE];
            if (wb.wb_dat_i[CTRL_COMMIT]) begin
              for (int unsigned k = 0; k < NB; k++) live[k] <= shadow[k];
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_VOL_RAMP_EN
  logic [15:0] pre_cnt;
  logic        tick;
  logic        pre_wr;

  // >= keeps the tick coming if PRESCALE is lowered below the running count.
  assign tick   = (pre_cnt >= prescale);
  assign pre_wr = req & wb.wb_we_i & ((region == REG_PRE_LO) | (region == REG_PRE_HI));

  // Prescaler: 0..PRESCALE, restarted by any PRESCALE write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (pre_wr || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    vol_ramp #(.VOL_W(VOL_W)) u_ramp (
      .clk    (clk),
      .rst    (rst),
`ifdef CSR_VOL_RAMP_EN
      .tick   (tick),
      .step   (step),
`endif
      .target (eff[ch*VOL_W +: VOL_W]),
      .cur    (vol[ch*VOL_W +: VOL_W]),
      .busy   (busy[ch])
    );
  end

endmodule
